// File: rtl/tree_node_pkg.sv
// Shared definitions for the decision-tree walker: node word layout,
// error codes and walker state encoding.
package tree_node_pkg;

  localparam int NODE_ID_MSB   = 63;
  localparam int NODE_ID_LSB   = 56;
  localparam int FEAT_ID_MSB   = 55;
  localparam int FEAT_ID_LSB   = 53;
  localparam int THRESH_MSB    = 52;
  localparam int THRESH_LSB    = 26;
  localparam int RIGHT_MSB     = 25;
  localparam int RIGHT_LSB     = 18;
  localparam int LEFT_MSB      = 17;
  localparam int LEFT_LSB      = 10;
  localparam int TYPE_MSB      = 9;
  localparam int TYPE_LSB      = 2;

  localparam int NODE_W        = 64;
  localparam int NODE_THRESH_W = THRESH_MSB - THRESH_LSB + 1;

  localparam logic [7:0] LEAF_TYPE = 8'h01;
  localparam logic [7:0] ROOT_ADDR = 8'd0;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DEPTH = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_NODE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tree_node_decode.sv
// Splits a 64-bit node memory word into its fields and flags leaf nodes.
module tree_node_decode
  import tree_node_pkg::*;
(
  input  logic [NODE_W-1:0]        node_word_i,
  output logic [7:0]               node_id_o,
  output logic [2:0]               feature_id_o,
  output logic [NODE_THRESH_W-1:0] threshold_o,
  output logic [7:0]               right_child_o,
  output logic [7:0]               left_child_o,
  output logic [7:0]               node_type_o,
  output logic                     is_leaf_o
);

  logic [1:0] unused_rsvd;

  assign node_id_o     = node_word_i[NODE_ID_MSB:NODE_ID_LSB];
  assign feature_id_o  = node_word_i[FEAT_ID_MSB:FEAT_ID_LSB];
  assign threshold_o   = node_word_i[THRESH_MSB:THRESH_LSB];
  assign right_child_o = node_word_i[RIGHT_MSB:RIGHT_LSB];
  assign left_child_o  = node_word_i[LEFT_MSB:LEFT_LSB];
  assign node_type_o   = node_word_i[TYPE_MSB:TYPE_LSB];
  assign unused_rsvd   = node_word_i[1:0];

  // A node with no children is terminal even if its type byte says otherwise.
  assign is_leaf_o = (node_type_o == LEAF_TYPE) ||
                     ((left_child_o == 8'd0) && (right_child_o == 8'd0));

endmodule

// File: rtl/tree_traverse_engine.sv
// Walks the decision tree from the root, one node read every two cycles,
// and reports the leaf class or the reason the walk was aborted.
module tree_traverse_engine
  import tree_node_pkg::*;
#(
  parameter int NUM_FEATURES = 8,
  parameter int FEAT_W       = 27,
  parameter int ADDR_W       = 8,
  parameter int NUM_NODES    = 173,
  parameter int MAX_DEPTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_FEATURES*FEAT_W-1:0] features,
  output logic                           busy,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [NODE_W-1:0]              mem_data,
  output logic                           result_valid,
  output logic [7:0]                     result_class,
  output logic                           result_error,
  output logic [1:0]                     error_code,
  output logic [5:0]                     depth
);

  state_e                         state_q, state_d;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q, feat_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic                           rd_en_q, rd_en_d;
  logic [5:0]                     depth_q, depth_d;
  logic [7:0]                     class_q, class_d;
  logic                           err_q, err_d;
  logic [1:0]                     code_q, code_d;

  logic [7:0]               dec_node_id;
  logic [2:0]               dec_feat_id;
  logic [NODE_THRESH_W-1:0] dec_thresh;
  logic [7:0]               dec_right;
  logic [7:0]               dec_left;
  logic [7:0]               dec_type;
  logic                     dec_is_leaf;

  tree_node_decode u_decode (
    .node_word_i   (mem_data),
    .node_id_o     (dec_node_id),
    .feature_id_o  (dec_feat_id),
    .threshold_o   (dec_thresh),
    .right_child_o (dec_right),
    .left_child_o  (dec_left),
    .node_type_o   (dec_type),
    .is_leaf_o     (dec_is_leaf)
  );

  logic [FEAT_W-1:0] feat_sel;
  logic [FEAT_W-1:0] thresh_cmp;
  logic [ADDR_W-1:0] next_addr;
  logic [5:0]        depth_inc;
  logic              bad_node;
  logic              range_err;
  logic              depth_err;
  logic [1:0]        fail_code;

  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (dec_feat_id == 3'(i)) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  assign thresh_cmp = FEAT_W'(dec_thresh);
  assign next_addr  = (feat_sel <= thresh_cmp) ? ADDR_W'(dec_left) : ADDR_W'(dec_right);
  assign depth_inc  = depth_q + 6'd1;
  assign bad_node   = (ADDR_W'(dec_node_id) != addr_q) ||
                      ({1'b0, dec_feat_id} >= 4'(NUM_FEATURES));
  assign range_err  = {1'b0, next_addr} >= (ADDR_W+1)'(NUM_NODES);
  assign depth_err  = depth_inc == 6'(MAX_DEPTH);

  // A bad node wins over everything; a valid leaf wins over range/depth aborts.
  always_comb begin
    fail_code = ERR_NONE;
    if (bad_node)         fail_code = ERR_NODE;
    else if (!dec_is_leaf) begin
      if (range_err)      fail_code = ERR_RANGE;
      else if (depth_err) fail_code = ERR_DEPTH;
    end
  end

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    depth_d = depth_q;
    class_d = class_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          feat_d  = features;
          addr_d  = ADDR_W'(ROOT_ADDR);
          rd_en_d = 1'b1;
          depth_d = 6'd0;
          state_d = WAIT;
        end
      end
      WAIT: state_d = EVAL;
      EVAL: begin
        depth_d = depth_inc;
        if (fail_code != ERR_NONE) begin
          err_d   = 1'b1;
          code_d  = fail_code;
          class_d = 8'd0;
          state_d = DONE;
        end else if (dec_is_leaf) begin
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          class_d = dec_thresh[7:0];
          state_d = DONE;
        end else begin
          addr_d  = next_addr;
          rd_en_d = 1'b1;
          state_d = WAIT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      feat_q  <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      depth_q <= 6'd0;
      class_q <= 8'd0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign result_class = class_q;
  assign result_error = err_q;
  assign error_code   = code_q;
  assign depth        = depth_q;

endmodule

// File: tb/tb_tree_traverse_engine.sv
// Bench for tree_traverse_engine: directed trees plus random trees checked
// against a plain walk of the node table.
module tb_tree_traverse_engine;

  localparam int NF = 8;
  localparam int FW = 27;
  localparam int AW = 8;
  localparam int NN = 173;
  localparam int MD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NF*FW-1:0] features;
  logic             busy;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [63:0]      mem_data;
  logic             result_valid;
  logic [7:0]       result_class;
  logic             result_error;
  logic [1:0]       error_code;
  logic [5:0]       depth;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [256];
  logic [FW-1:0] fv [NF];
  int  rv_cnt = 0;
  bit  saw200 = 0;
  logic [7:0] last_class = 8'd0;
  logic       last_err   = 1'b0;
  logic [1:0] last_code  = 2'd0;

  tree_traverse_engine #(
    .NUM_FEATURES(NF), .FEAT_W(FW), .ADDR_W(AW), .NUM_NODES(NN), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .features(features),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .result_valid(result_valid), .result_class(result_class),
    .result_error(result_error), .error_code(error_code), .depth(depth)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
    if (result_valid === 1'b1) rv_cnt++;
    if (mem_addr === 8'd200) saw200 = 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] mk(input logic [7:0] id, input logic [2:0] fid,
                                     input logic [26:0] thr, input logic [7:0] r,
                                     input logic [7:0] l, input logic [7:0] typ);
    return {id, fid, thr, r, l, typ, 2'b00};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
  endtask

  // Reference: follow the tree node by node using the node-table rules.
  task automatic model(output logic [7:0] cls, output logic er,
                       output logic [1:0] code, output int d);
    int addr;
    int nxt;
    logic [63:0] w;
    addr = 0; d = 0; cls = 8'd0; er = 1'b0; code = 2'd0;
    while (1) begin
      w = mem[addr];
      d++;
      if (int'(w[63:56]) != addr || int'(w[55:53]) >= NF) begin
        er = 1'b1; code = 2'd3; return;
      end
      if (w[9:2] == 8'h01 || (w[25:18] == 8'd0 && w[17:10] == 8'd0)) begin
        cls = w[33:26]; return;
      end
      nxt = (fv[w[55:53]] <= w[52:26]) ? int'(w[17:10]) : int'(w[25:18]);
      if (nxt >= NN) begin er = 1'b1; code = 2'd2; return; end
      if (d == MD)   begin er = 1'b1; code = 2'd1; return; end
      addr = nxt;
    end
  endtask

  task automatic do_walk(input string name, input bit hold);
    logic [7:0] ecls;
    logic       eer;
    logic [1:0] ecode;
    int ed, n, rv0;
    bit got, held_ok;
    model(ecls, eer, ecode, ed);
    @(negedge clk);
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = fv[i];
    start = 1'b1;
    rv0 = rv_cnt;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = FW'($urandom);
    n = 1; got = 0; held_ok = 1;
    while (n < 200 && !got) begin
      if (result_valid === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1 || result_class !== last_class ||
            result_error !== last_err || error_code !== last_code) held_ok = 0;
        @(posedge clk); #1;
        n++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: result_valid not seen within %0d cycles", name, n);
      start = 1'b0;
      return;
    end
    checks++;
    if (n !== 2*ed+1) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, n, 2*ed+1);
    end
    checks++;
    if (result_class !== ecls) begin
      errors++; $display("FAIL %s class: got %0d want %0d", name, result_class, ecls);
    end
    checks++;
    if (result_error !== eer || error_code !== ecode) begin
      errors++;
      $display("FAIL %s error: got %0b/%0d want %0b/%0d", name, result_error, error_code, eer, ecode);
    end
    checks++;
    if (int'(depth) !== ed) begin
      errors++; $display("FAIL %s depth: got %0d want %0d", name, depth, ed);
    end
    checks++;
    if (!held_ok) begin
      errors++; $display("FAIL %s hold: busy/result changed before result_valid got 0 want 1", name);
    end
    last_class = ecls; last_err = eer; last_code = ecode;
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || (rv_cnt - rv0) !== 1 ||
        result_class !== ecls || error_code !== ecode) begin
      errors++;
      $display("FAIL %s after_done: rv=%0b busy=%0b pulses=%0d class=%0d want rv=0 busy=0 pulses=1 class=%0d",
               name, result_valid, busy, rv_cnt - rv0, result_class, ecls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; features = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || result_valid !== 1'b0 || result_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%0b rd=%0b rv=%0b err=%0b want all 0", busy, mem_rd_en, result_valid, result_error);
    end
    checks++;
    if (mem_addr !== 8'd0 || result_class !== 8'd0 || error_code !== 2'd0 || depth !== 6'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d class=%0d code=%0d depth=%0d want all 0", mem_addr, result_class, error_code, depth);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_root_leaf();
    clear_mem();
    mem[0] = mk(8'd0, 3'd0, 27'd5, 8'd0, 8'd0, 8'h01);
    for (int i = 0; i < NF; i++) fv[i] = FW'($urandom);
    do_walk("root_leaf", 0);
  endtask

  task automatic load_three_node();
    clear_mem();
    mem[0] = mk(8'd0, 3'd2, 27'd1000, 8'd2, 8'd1, 8'h00);
    mem[1] = mk(8'd1, 3'd0, 27'd3, 8'd0, 8'd0, 8'h01);
    mem[2] = mk(8'd2, 3'd0, 27'd7, 8'd0, 8'd0, 8'h01);
  endtask

  task automatic test_three_node();
    load_three_node();
    for (int i = 0; i < NF; i++) fv[i] = FW'($urandom);
    fv[2] = 27'd1000;      do_walk("three_eq", 0);
    fv[2] = 27'd1001;      do_walk("three_gt", 0);
    fv[2] = 27'h7FFFFFF;   do_walk("three_max", 0);
  endtask

  task automatic test_range();
    clear_mem();
    mem[0] = mk(8'd0, 3'd0, 27'd10, 8'd200, 8'd1, 8'h00);
    mem[1] = mk(8'd1, 3'd0, 27'd4, 8'd0, 8'd0, 8'h01);
    fv[0] = 27'd11;
    saw200 = 0;
    do_walk("range", 0);
    checks++;
    if (saw200) begin
      errors++; $display("FAIL range_addr: mem_addr reached 200 got 1 want 0");
    end
  endtask

  task automatic test_depth();
    clear_mem();
    for (int i = 0; i < 8; i++)
      mem[i] = mk(8'(i), 3'd1, 27'h7FFFFFF, 8'(i+1), 8'(i+1), 8'h00);
    fv[1] = FW'($urandom);
    do_walk("depth_abort", 0);
    mem[3] = mk(8'd3, 3'd0, 27'h2A, 8'd0, 8'd0, 8'h01);
    do_walk("depth_leaf_last", 0);
  endtask

  task automatic test_back_to_back();
    int n;
    int rv0;
    clear_mem();
    mem[0] = mk(8'd9, 3'd0, 27'd0, 8'd0, 8'd0, 8'h01);
    do_walk("b2b_first", 1);
    rv0 = rv_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: busy got %0b want 1", busy);
    end
    n = 0;
    while (result_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 2 || error_code !== 2'd3 || result_error !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: wait=%0d code=%0d err=%0b want wait=2 code=3 err=1", n, error_code, result_error);
    end
    @(posedge clk); #1;
    checks++;
    if ((rv_cnt - rv0) !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_pulses: got %0d busy=%0b want 1 busy=0", rv_cnt - rv0, busy);
    end
  endtask

  task automatic test_reset_midwalk();
    int rv0;
    load_three_node();
    fv[2] = 27'd5000;
    @(negedge clk);
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = fv[i];
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 8'd2) begin
      errors++; $display("FAIL mid_second_read: rd=%0b addr=%0d want rd=1 addr=2", mem_rd_en, mem_addr);
    end
    rst = 1'b1;
    rv0 = rv_cnt;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%0b rv=%0b rd=%0b want 0 0 0", busy, result_valid, mem_rd_en);
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (rv_cnt !== rv0 || result_class !== 8'd0 || depth !== 6'd0) begin
      errors++; $display("FAIL mid_no_result: pulses=%0d class=%0d depth=%0d want 0 0 0", rv_cnt - rv0, result_class, depth);
    end
    last_class = 8'd0; last_err = 1'b0; last_code = 2'd0;
    do_walk("after_reset", 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      clear_mem();
      for (int i = 0; i < 16; i++) begin
        logic [7:0] id, l, r, typ;
        id  = ($urandom_range(0, 19) == 0) ? 8'(i + 1) : 8'(i);
        l   = ($urandom_range(0, 11) == 0) ? 8'd200 : 8'($urandom_range(0, 15));
        r   = ($urandom_range(0, 11) == 0) ? 8'd180 : 8'($urandom_range(0, 15));
        typ = ($urandom_range(0, 5) == 0) ? 8'h01 : 8'($urandom);
        mem[i] = mk(id, 3'($urandom), 27'($urandom), r, l, typ);
      end
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < NF; i++) fv[i] = FW'($urandom);
        do_walk($sformatf("rand_%0d_%0d", t, k), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; features = '0;
    for (int i = 0; i < NF; i++) fv[i] = '0;
    clear_mem();
    test_reset();
    test_root_leaf();
    test_three_node();
    test_range();
    test_depth();
    test_back_to_back();
    test_reset_midwalk();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
